// File: rtl/mmio_arbiter_pkg.sv
// Shared types and constants for the mmio arbiter: FSM states, latched command
// layout and the MMIO address map used by the requesters.
package mmio_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StRead  = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic        byte_select;
        logic        byte_enable;
        logic [15:0] wdata;
    } mmio_cmd_t;

    localparam logic [15:0] MmioLedAddr      = 16'hff00;
    localparam logic [15:0] MmioUartDataAddr = 16'hff02;
    localparam logic [15:0] MmioSwitchAddr   = 16'hff04;
    localparam logic [15:0] MmioSoundAddr    = 16'hff06;
    localparam logic [15:0] MmioTimerAddr    = 16'hff08;
    localparam logic [15:0] MmioDmaCtrlAddr  = 16'hff20;

    // Counter width for a 0..max_wait saturating count, never narrower than 1 bit.
    function automatic int unsigned starve_width(input int unsigned max_wait);
        return (max_wait == 0) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mmio_arb_starve.sv
// Saturating DMA starvation counter; flags when DMA has lost DMA_MAX_WAIT cycles
// in a row and must win the next arbitration.
module mmio_arb_starve
    import mmio_arbiter_pkg::*;
#(
    parameter int unsigned DMA_MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_granted,
    output logic starved
);

    localparam int unsigned W = starve_width(DMA_MAX_WAIT);
    localparam logic [W-1:0] MaxCount = W'(DMA_MAX_WAIT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!dma_req || dma_granted) begin
            count_d = '0;
        end else if (count_q != MaxCount) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count saturates, so equality is the same as reaching the threshold.
    assign starved = (count_q == MaxCount);

endmodule

// File: rtl/mmio_arbiter.sv
// Two-requester (CPU, DMA) arbiter for the single mmio port: grant, issue with
// stall stretching, read capture and a one-cycle registered ack.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int unsigned DMA_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_byte_select,
    input  logic        cpu_byte_enable,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic        dma_byte_select,
    input  logic        dma_byte_enable,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic        mmio_en,
    output logic        mmio_write_enable,
    output logic [15:0] mmio_addr,
    output logic        mmio_byte_select,
    output logic        mmio_byte_enable,
    output logic [15:0] mmio_wdata,
    input  logic [15:0] mmio_rdata,
    input  logic        mmio_wait,
    output logic        grant_dma,
    output logic        busy
);

    arb_state_e  state_q, state_d;
    mmio_cmd_t   cmd_q, cmd_d;
    mmio_cmd_t   cpu_cmd, dma_cmd;
    logic        grant_dma_q, grant_dma_d;
    logic [15:0] cpu_rdata_q, dma_rdata_q;
    logic        starved, dma_wins, dma_grant_now, dma_granted;

    assign cpu_cmd = '{we: cpu_we, addr: cpu_addr, byte_select: cpu_byte_select,
                       byte_enable: cpu_byte_enable, wdata: cpu_wdata};
    assign dma_cmd = '{we: dma_we, addr: dma_addr, byte_select: dma_byte_select,
                       byte_enable: dma_byte_enable, wdata: dma_wdata};

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        grant_dma_d   = grant_dma_q;
        dma_wins      = 1'b0;
        dma_grant_now = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cpu_req || dma_req) begin
                    dma_wins      = dma_req && (starved || !cpu_req);
                    dma_grant_now = dma_wins;
                    grant_dma_d   = dma_wins;
                    cmd_d         = dma_wins ? dma_cmd : cpu_cmd;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                if (!mmio_wait) begin
                    state_d = cmd_q.we ? StDone : StRead;
                end
            end
            StRead:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            grant_dma_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            grant_dma_q <= grant_dma_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (state_q == StRead) begin
            if (grant_dma_q) begin
                dma_rdata_q <= mmio_rdata;
            end else begin
                cpu_rdata_q <= mmio_rdata;
            end
        end
    end

    // DMA counts as granted for the whole of its own transaction, not just the grant cycle.
    assign dma_granted = dma_grant_now || ((state_q != StIdle) && grant_dma_q);

    mmio_arb_starve #(
        .DMA_MAX_WAIT(DMA_MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .dma_req    (dma_req),
        .dma_granted(dma_granted),
        .starved    (starved)
    );

    assign mmio_en           = (state_q == StIssue);
    assign mmio_write_enable = mmio_en && cmd_q.we;
    assign mmio_addr         = cmd_q.addr;
    assign mmio_byte_select  = cmd_q.byte_select;
    assign mmio_byte_enable  = cmd_q.byte_enable;
    assign mmio_wdata        = cmd_q.wdata;
    assign cpu_ack           = (state_q == StDone) && !grant_dma_q;
    assign dma_ack           = (state_q == StDone) && grant_dma_q;
    assign cpu_rdata         = cpu_rdata_q;
    assign dma_rdata         = dma_rdata_q;
    assign grant_dma         = grant_dma_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: directed scenarios plus randomized traffic
// against a transaction-level arbitration/latency model.
module tb_mmio_arbiter;
    import mmio_arbiter_pkg::*;

    localparam int MaxWait = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_byte_select, cpu_byte_enable, cpu_ack;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_byte_select, dma_byte_enable, dma_ack;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        mmio_en, mmio_write_enable, mmio_byte_select, mmio_byte_enable;
    logic [15:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic        mmio_wait, grant_dma, busy;

    always #5 clk = ~clk;

    mmio_arbiter #(
        .DMA_MAX_WAIT(MaxWait)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_req          (cpu_req),
        .cpu_we           (cpu_we),
        .cpu_addr         (cpu_addr),
        .cpu_byte_select  (cpu_byte_select),
        .cpu_byte_enable  (cpu_byte_enable),
        .cpu_wdata        (cpu_wdata),
        .cpu_ack          (cpu_ack),
        .cpu_rdata        (cpu_rdata),
        .dma_req          (dma_req),
        .dma_we           (dma_we),
        .dma_addr         (dma_addr),
        .dma_byte_select  (dma_byte_select),
        .dma_byte_enable  (dma_byte_enable),
        .dma_wdata        (dma_wdata),
        .dma_ack          (dma_ack),
        .dma_rdata        (dma_rdata),
        .mmio_en          (mmio_en),
        .mmio_write_enable(mmio_write_enable),
        .mmio_addr        (mmio_addr),
        .mmio_byte_select (mmio_byte_select),
        .mmio_byte_enable (mmio_byte_enable),
        .mmio_wdata       (mmio_wdata),
        .mmio_rdata       (mmio_rdata),
        .mmio_wait        (mmio_wait),
        .grant_dma        (grant_dma),
        .busy             (busy)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic        bs;
        logic        be;
        logic [15:0] wdata;
    } req_t;

    int          total = 0;
    int          bad = 0;
    req_t        cpu_c, dma_c;
    bit          cpu_pend, dma_pend;
    int          model_wait;
    logic [15:0] exp_cpu_rd, exp_dma_rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        cpu_req = cpu_pend; cpu_we = cpu_c.we; cpu_addr = cpu_c.addr;
        cpu_byte_select = cpu_c.bs; cpu_byte_enable = cpu_c.be; cpu_wdata = cpu_c.wdata;
        dma_req = dma_pend; dma_we = dma_c.we; dma_addr = dma_c.addr;
        dma_byte_select = dma_c.bs; dma_byte_enable = dma_c.be; dma_wdata = dma_c.wdata;
    endtask

    function automatic req_t mk_req(input logic we, input logic [15:0] addr,
                                    input logic [15:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        r.bs = 1'($urandom); r.be = 1'($urandom);
        return r;
    endfunction

    function automatic logic [71:0] all_outs();
        return {cpu_ack, cpu_rdata, dma_ack, dma_rdata, mmio_en, mmio_write_enable, mmio_addr,
                mmio_byte_select, mmio_byte_enable, mmio_wdata, grant_dma, busy};
    endfunction

    // Runs one transaction from an IDLE cycle: w stall cycles, rd_val returned on a read.
    task automatic run_txn(input int w, input logic [15:0] rd_val, output logic g_obs);
        bit   wd;
        req_t c;
        int   dur;
        wd = dma_pend && (model_wait >= MaxWait || !cpu_pend);
        c  = wd ? dma_c : cpu_c;
        drive_reqs();
        mmio_wait = 1'b0;
        step();
        g_obs = grant_dma;
        // Inputs after grant must be ignored, including a dropped req.
        if (wd) begin
            dma_req = 1'($urandom); dma_we = 1'($urandom); dma_addr = 16'($urandom);
            dma_wdata = 16'($urandom); dma_byte_select = 1'($urandom);
        end else begin
            cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 16'($urandom);
            cpu_wdata = 16'($urandom); cpu_byte_enable = 1'($urandom);
        end
        for (int k = 0; k <= w; k++) begin
            mmio_wait = (k < w);
            total++;
            if ({mmio_en, mmio_write_enable, mmio_addr, mmio_byte_select, mmio_byte_enable,
                 mmio_wdata, grant_dma, busy, cpu_ack, dma_ack, cpu_rdata, dma_rdata} !==
                {1'b1, c.we, c.addr, c.bs, c.be, c.wdata, wd, 1'b1, 2'b00, exp_cpu_rd,
                 exp_dma_rd}) begin
                bad++;
                $display("FAIL issue k=%0d got en=%b we=%b addr=%h wd=%h g=%b acks=%b%b want we=%b addr=%h wd=%h g=%b",
                         k, mmio_en, mmio_write_enable, mmio_addr, mmio_wdata, grant_dma,
                         cpu_ack, dma_ack, c.we, c.addr, c.wdata, wd);
            end
            step();
        end
        mmio_wait = 1'b0;
        if (!c.we) begin
            mmio_rdata = rd_val;
            total++;
            if ({mmio_en, mmio_write_enable, busy, cpu_ack, dma_ack} !== 5'b00100) begin
                bad++;
                $display("FAIL read_cycle got en/we/busy/acks=%b want=00100",
                         {mmio_en, mmio_write_enable, busy, cpu_ack, dma_ack});
            end
            step();
            mmio_rdata = 16'($urandom);
            if (wd) exp_dma_rd = rd_val; else exp_cpu_rd = rd_val;
        end
        total++;
        if ({cpu_ack, dma_ack, cpu_rdata, dma_rdata, mmio_en, grant_dma, busy} !==
            {!wd, wd, exp_cpu_rd, exp_dma_rd, 1'b0, wd, 1'b1}) begin
            bad++;
            $display("FAIL done acks=%b%b rd=%h/%h en=%b g=%b busy=%b want acks=%b%b rd=%h/%h",
                     cpu_ack, dma_ack, cpu_rdata, dma_rdata, mmio_en, grant_dma, busy,
                     !wd, wd, exp_cpu_rd, exp_dma_rd);
        end
        if (wd) dma_pend = 1'b0; else cpu_pend = 1'b0;
        drive_reqs();
        step();
        total++;
        if ({cpu_ack, dma_ack, mmio_en, busy, cpu_rdata, dma_rdata} !==
            {4'b0000, exp_cpu_rd, exp_dma_rd}) begin
            bad++;
            $display("FAIL idle_after got acks=%b%b en=%b busy=%b rd=%h/%h want 0000 rd=%h/%h",
                     cpu_ack, dma_ack, mmio_en, busy, cpu_rdata, dma_rdata, exp_cpu_rd,
                     exp_dma_rd);
        end
        dur = (c.we ? 3 : 4) + w;
        if (wd || !dma_pend) model_wait = 0;
        else model_wait = (model_wait + dur > MaxWait) ? MaxWait : model_wait + dur;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (all_outs() !== 72'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", all_outs());
        end
        step();
        step();
        rst = 1'b0;
        step();
        total++;
        if (all_outs() !== 72'd0) begin
            bad++;
            $display("FAIL post_reset_idle got=%h want=0", all_outs());
        end
    endtask

    task automatic test_cpu_write_led();
        logic g;
        cpu_c = mk_req(1'b1, MmioLedAddr, 16'h00A5);
        cpu_pend = 1'b1;
        run_txn(0, 16'h0, g);
    endtask

    task automatic test_cpu_read_timer();
        logic g;
        cpu_c = mk_req(1'b0, MmioTimerAddr, 16'h0);
        cpu_pend = 1'b1;
        run_txn(0, 16'h1234, g);
    endtask

    task automatic test_dma_read();
        logic g;
        dma_c = mk_req(1'b0, MmioDmaCtrlAddr, 16'h0);
        dma_pend = 1'b1;
        run_txn(0, 16'h0001, g);
        total++;
        if (g !== 1'b1) begin
            bad++;
            $display("FAIL dma_read_grant got=%b want=1", g);
        end
    endtask

    task automatic test_uart_wait();
        logic g;
        cpu_c = mk_req(1'b1, MmioUartDataAddr, 16'h0041);
        cpu_pend = 1'b1;
        run_txn(5, 16'h0, g);
    endtask

    task automatic test_starvation();
        logic g;
        logic exp_seq [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            if (!cpu_pend) begin
                cpu_c = mk_req(1'b1, MmioSoundAddr, 16'($urandom));
                cpu_pend = 1'b1;
            end
            if (!dma_pend) begin
                dma_c = mk_req(1'b1, MmioLedAddr, 16'($urandom));
                dma_pend = 1'b1;
            end
            run_txn(0, 16'h0, g);
            total++;
            if (g !== exp_seq[i]) begin
                bad++;
                $display("FAIL starve_seq i=%0d got grant_dma=%b want=%b", i, g, exp_seq[i]);
            end
        end
        dma_pend = 1'b0;
        drive_reqs();
        step();
        model_wait = 0;
    endtask

    task automatic test_reset_mid_read();
        logic g;
        cpu_c = mk_req(1'b0, MmioTimerAddr, 16'h0);
        cpu_pend = 1'b1;
        drive_reqs();
        step();
        step();
        mmio_rdata = 16'hbeef;
        rst = 1'b1;
        #1;
        total++;
        if (all_outs() !== 72'd0) begin
            bad++;
            $display("FAIL reset_async got=%h want=0", all_outs());
        end
        cpu_pend = 1'b0;
        dma_pend = 1'b0;
        drive_reqs();
        step();
        total++;
        if ({cpu_ack, dma_ack, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_no_ack got=%b want=000", {cpu_ack, dma_ack, busy});
        end
        rst = 1'b0;
        exp_cpu_rd = 16'h0;
        exp_dma_rd = 16'h0;
        model_wait = 0;
        step();
        cpu_c = mk_req(1'b1, MmioLedAddr, 16'h005A);
        cpu_pend = 1'b1;
        run_txn(0, 16'h0, g);
    endtask

    task automatic test_random();
        logic g;
        logic [15:0] addrs [6] = '{MmioLedAddr, MmioUartDataAddr, MmioSwitchAddr,
                                   MmioSoundAddr, MmioTimerAddr, MmioDmaCtrlAddr};
        for (int i = 0; i < 60; i++) begin
            if (!cpu_pend && $urandom_range(0, 2) != 0) begin
                cpu_c = mk_req(1'($urandom), addrs[$urandom_range(0, 5)], 16'($urandom));
                cpu_pend = 1'b1;
            end
            if (!dma_pend && $urandom_range(0, 2) != 0) begin
                dma_c = mk_req(1'($urandom), 16'($urandom), 16'($urandom));
                dma_pend = 1'b1;
            end
            if (!cpu_pend && !dma_pend) begin
                cpu_c = mk_req(1'($urandom), addrs[$urandom_range(0, 5)], 16'($urandom));
                cpu_pend = 1'b1;
            end
            run_txn($urandom_range(0, 3), 16'($urandom), g);
        end
    endtask

    initial begin
        cpu_pend = 1'b0;
        dma_pend = 1'b0;
        cpu_c = '0;
        dma_c = '0;
        model_wait = 0;
        exp_cpu_rd = 16'h0;
        exp_dma_rd = 16'h0;
        mmio_rdata = 16'h0;
        mmio_wait = 1'b0;
        drive_reqs();
        test_reset();
        test_cpu_write_led();
        test_cpu_read_timer();
        test_dma_read();
        test_uart_wait();
        test_starvation();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
